// File: rtl/scu_apb_reg_bus_initiator.sv
// rtl/scu_apb_reg_bus_initiator.sv - APB4 completer mastering the SCU register bus
// One APB transfer yields exactly one register-bus access, bounded by a ready timeout.
module scu_apb_reg_bus_initiator #(
  parameter int unsigned P_BUS_ADDR_WIDTH = 24,
  parameter int unsigned P_RESPONSE_WIDTH = 3,
  parameter int unsigned P_TIMEOUT_CYCLES = 255,
  parameter int unsigned P_ERR_CNT_WIDTH  = 16
) (
  input  logic                        clk_i,
  input  logic                        resetn_i,
  input  logic                        psel_i,
  input  logic                        penable_i,
  input  logic                        pwrite_i,
  input  logic [31:0]                 paddr_i,
  input  logic [31:0]                 pwdata_i,
  input  logic [3:0]                  pstrb_i,
  output logic [31:0]                 prdata_o,
  output logic                        pready_o,
  output logic                        pslverr_o,
  output logic                        bus_csb_o,
  output logic                        bus_wr_o,
  output logic [P_BUS_ADDR_WIDTH-1:0] bus_address_o,
  output logic [31:0]                 bus_write_data_o,
  output logic [3:0]                  bus_byte_en_o,
  input  logic [31:0]                 bus_read_data_i,
  input  logic                        bus_ready_i,
  input  logic [P_RESPONSE_WIDTH-1:0] bus_response_i,
  output logic                        timeout_o,
  output logic [P_ERR_CNT_WIDTH-1:0]  err_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RSP,
    S_ACK
  } state_e;

  localparam bit          TMO_EN     = (P_TIMEOUT_CYCLES != 0);
  localparam int unsigned TMO_LAST_I = TMO_EN ? (P_TIMEOUT_CYCLES - 1) : 0;
  localparam logic [15:0] TMO_LAST   = TMO_LAST_I[15:0];
  localparam logic [31:0] TMO_RDATA  = 32'hDEAD_DEAD;

  state_e                      state_q;
  logic [15:0]                 tmo_cnt_q;
  logic [31:0]                 prdata_q;
  logic                        pready_q;
  logic                        pslverr_q;
  logic                        csb_q;
  logic                        wr_q;
  logic [P_BUS_ADDR_WIDTH-1:0] addr_q;
  logic [31:0]                 wdata_q;
  logic [3:0]                  be_q;
  logic                        timeout_q;
  logic [P_ERR_CNT_WIDTH-1:0]  err_cnt_q;
  logic [P_ERR_CNT_WIDTH-1:0]  err_cnt_d;
  logic                        tmo_hit;

  assign err_cnt_d = (err_cnt_q == {P_ERR_CNT_WIDTH{1'b1}}) ? err_cnt_q
                                                             : err_cnt_q + 1'b1;
  assign tmo_hit   = TMO_EN && (tmo_cnt_q == TMO_LAST);

  generate
    if (P_BUS_ADDR_WIDTH < 32) begin : g_addr_unused
      logic unused_paddr_hi;
      assign unused_paddr_hi = ^paddr_i[31:P_BUS_ADDR_WIDTH];
    end
  endgenerate

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q   <= S_IDLE;
      tmo_cnt_q <= '0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      csb_q     <= 1'b1;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      timeout_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      pready_q  <= 1'b0;
      timeout_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (psel_i && !penable_i) begin
            wr_q    <= pwrite_i;
            addr_q  <= paddr_i[P_BUS_ADDR_WIDTH-1:0];
            wdata_q <= pwdata_i;
            be_q    <= pwrite_i ? pstrb_i : 4'hF;
            csb_q   <= 1'b0;
            state_q <= S_REQ;
          end
        end
        S_REQ: begin
          if (bus_ready_i) begin
            csb_q   <= 1'b1;
            state_q <= S_RSP;
          end else if (tmo_hit) begin
            // Slave never accepted: abandon the request and fail the APB transfer.
            csb_q     <= 1'b1;
            timeout_q <= 1'b1;
            pready_q  <= 1'b1;
            pslverr_q <= 1'b1;
            prdata_q  <= TMO_RDATA;
            state_q   <= S_ACK;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 16'd1;
          end
        end
        S_RSP: begin
          pready_q  <= 1'b1;
          pslverr_q <= (bus_response_i != '0);
          prdata_q  <= wr_q ? 32'h0 : bus_read_data_i;
          state_q   <= S_ACK;
        end
        S_ACK: begin
          if (pslverr_q) begin
            err_cnt_q <= err_cnt_d;
          end
          pslverr_q <= 1'b0;
          prdata_q  <= '0;
          addr_q    <= '0;
          wdata_q   <= '0;
          be_q      <= '0;
          tmo_cnt_q <= '0;
          state_q   <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign prdata_o         = prdata_q;
  assign pready_o         = pready_q;
  assign pslverr_o        = pslverr_q;
  assign bus_csb_o        = csb_q;
  assign bus_wr_o         = wr_q;
  assign bus_address_o    = addr_q;
  assign bus_write_data_o = wdata_q;
  assign bus_byte_en_o    = be_q;
  assign timeout_o        = timeout_q;
  assign err_cnt_o        = err_cnt_q;

endmodule

// File: tb/tb_scu_apb_reg_bus_initiator.sv
// tb/tb_scu_apb_reg_bus_initiator.sv - randomized self-checking bench for scu_apb_reg_bus_initiator
// A cycle-schedule model predicts every bus and APB output from the transfer parameters.
module tb_scu_apb_reg_bus_initiator;

  localparam int TO = 8;

  logic        clk_i = 1'b0;
  logic        resetn_i = 1'b1;
  logic        psel_i = 1'b0;
  logic        penable_i = 1'b0;
  logic        pwrite_i = 1'b0;
  logic [31:0] paddr_i = '0;
  logic [31:0] pwdata_i = '0;
  logic [3:0]  pstrb_i = '0;
  logic [31:0] prdata_o;
  logic        pready_o;
  logic        pslverr_o;
  logic        bus_csb_o;
  logic        bus_wr_o;
  logic [23:0] bus_address_o;
  logic [31:0] bus_write_data_o;
  logic [3:0]  bus_byte_en_o;
  logic [31:0] bus_read_data_i = '0;
  logic        bus_ready_i = 1'b0;
  logic [2:0]  bus_response_i = '0;
  logic        timeout_o;
  logic [3:0]  err_cnt_o;

  scu_apb_reg_bus_initiator #(
    .P_BUS_ADDR_WIDTH(24),
    .P_RESPONSE_WIDTH(3),
    .P_TIMEOUT_CYCLES(TO),
    .P_ERR_CNT_WIDTH(4)
  ) dut (
    .clk_i           (clk_i),
    .resetn_i        (resetn_i),
    .psel_i          (psel_i),
    .penable_i       (penable_i),
    .pwrite_i        (pwrite_i),
    .paddr_i         (paddr_i),
    .pwdata_i        (pwdata_i),
    .pstrb_i         (pstrb_i),
    .prdata_o        (prdata_o),
    .pready_o        (pready_o),
    .pslverr_o       (pslverr_o),
    .bus_csb_o       (bus_csb_o),
    .bus_wr_o        (bus_wr_o),
    .bus_address_o   (bus_address_o),
    .bus_write_data_o(bus_write_data_o),
    .bus_byte_en_o   (bus_byte_en_o),
    .bus_read_data_i (bus_read_data_i),
    .bus_ready_i     (bus_ready_i),
    .bus_response_i  (bus_response_i),
    .timeout_o       (timeout_o),
    .err_cnt_o       (err_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_total = 0;
  int n_pass  = 0;

  // Model of the transfer currently in flight, keyed by its setup cycle.
  int          m_t0 = -100;
  int          m_delay = 0;
  bit          m_wr = 1'b0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_wdata = '0;
  logic [3:0]  m_strb = '0;
  logic [31:0] m_rdata = '0;
  logic [2:0]  m_resp = '0;
  bit          m_tmo = 1'b0;
  int          m_err = 0;

  int          obs_lat, obs_csb_low, obs_acc;
  logic [31:0] obs_prdata;
  logic        obs_pslverr, obs_tmo;
  logic [3:0]  obs_be;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  int  c_nlow, c_tack;
  bit  c_inreq;
  always @(negedge clk_i) begin
    c_nlow  = m_tmo ? TO : m_delay + 1;
    c_tack  = m_tmo ? m_t0 + TO + 1 : m_t0 + m_delay + 3;
    c_inreq = (cyc >= m_t0 + 1) && (cyc <= m_t0 + c_nlow);
    chk("csb", {31'd0, bus_csb_o}, {31'd0, !c_inreq});
    chk("pready", {31'd0, pready_o}, {31'd0, cyc == c_tack});
    chk("timeout", {31'd0, timeout_o}, {31'd0, m_tmo && (cyc == c_tack)});
    if (c_inreq && !bus_csb_o) begin
      chk("bus_wr", {31'd0, bus_wr_o}, {31'd0, m_wr});
      chk("bus_addr", {8'd0, bus_address_o}, {8'd0, m_addr[23:0]});
      chk("bus_wdata", bus_write_data_o, m_wdata);
      chk("bus_be", {28'd0, bus_byte_en_o}, {28'd0, m_wr ? m_strb : 4'hF});
    end
    if ((cyc == c_tack) && pready_o) begin
      chk("prdata", prdata_o, m_tmo ? 32'hDEAD_DEAD : (m_wr ? 32'h0 : m_rdata));
      chk("pslverr", {31'd0, pslverr_o}, {31'd0, m_tmo || (m_resp != 3'd0)});
    end
  end

  task automatic drive_slave();
    bus_ready_i = (cyc >= m_t0 + 1 + m_delay);
    if (cyc == m_t0 + 2 + m_delay) begin
      bus_read_data_i = m_rdata;
      bus_response_i  = m_resp;
    end else begin
      bus_read_data_i = $urandom;
      bus_response_i  = 3'($urandom);
    end
  endtask

  task automatic apb_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input int delay, input logic [31:0] rdata,
                          input logic [2:0] resp, input bit drop);
    int exp_lat;
    bit err;
    m_t0 = cyc; m_delay = delay; m_wr = wr; m_addr = addr; m_wdata = wdata;
    m_strb = strb; m_rdata = rdata; m_resp = resp; m_tmo = (delay >= TO);
    err     = m_tmo || (resp != 3'd0);
    exp_lat = m_tmo ? TO + 1 : delay + 3;
    psel_i = 1'b1; penable_i = 1'b0; pwrite_i = wr;
    paddr_i = addr; pwdata_i = wdata; pstrb_i = strb;
    drive_slave();
    obs_lat = -1; obs_csb_low = 0; obs_acc = 0; obs_be = '0;
    obs_prdata = '0; obs_pslverr = 1'b0; obs_tmo = 1'b0;
    for (int k = 1; k <= 40 && obs_lat < 0; k++) begin
      @(posedge clk_i); #2;
      if (drop) begin
        psel_i = 1'b0; penable_i = 1'b0;
        paddr_i = $urandom; pwdata_i = $urandom; pwrite_i = 1'($urandom);
      end else begin
        penable_i = 1'b1;
      end
      drive_slave();
      if (!bus_csb_o) begin
        obs_csb_low++;
        obs_be = bus_byte_en_o;
        if (bus_ready_i) obs_acc++;
      end
      if (pready_o) begin
        obs_lat = k; obs_prdata = prdata_o; obs_pslverr = pslverr_o; obs_tmo = timeout_o;
      end
    end
    chk("latency", obs_lat, exp_lat);
    chk("csb_low_cycles", obs_csb_low, m_tmo ? TO : delay + 1);
    chk("accepts", obs_acc, m_tmo ? 0 : 1);
    if (err) m_err = (m_err == 15) ? 15 : m_err + 1;
    @(posedge clk_i); #2;
    psel_i = 1'b0; penable_i = 1'b0;
    bus_ready_i = 1'($urandom);
    chk("err_cnt", {28'd0, err_cnt_o}, m_err);
  endtask

  task automatic do_reset();
    resetn_i = 1'b0; m_t0 = -100; m_err = 0;
    psel_i = 1'b0; penable_i = 1'b0;
    @(posedge clk_i); #2;
    @(posedge clk_i); #2;
    resetn_i = 1'b1;
  endtask

  initial begin
    #(100000 * 10);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d, r, gaps;
    #1 resetn_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #2;
    chk("rst_csb", {31'd0, bus_csb_o}, 32'd1);
    chk("rst_pready", {31'd0, pready_o}, 32'd0);
    chk("rst_err", {28'd0, err_cnt_o}, 32'd0);
    chk("rst_addr", {8'd0, bus_address_o}, 32'd0);
    resetn_i = 1'b1;
    @(posedge clk_i); #2;

    apb_xfer(1'b1, 32'h0000_0044, 32'hA5A5_1234, 4'b0011, 0, 32'h0, 3'd0, 1'b0);
    chk("w_lat", obs_lat, 32'd3);
    chk("w_csb", obs_csb_low, 32'd1);
    chk("w_be", {28'd0, obs_be}, 32'h3);
    chk("w_slverr", {31'd0, obs_pslverr}, 32'd0);

    apb_xfer(1'b0, 32'h0000_0010, 32'hFFFF_0000, 4'h0, 0, 32'h1234_5678, 3'd0, 1'b0);
    chk("r_prdata", obs_prdata, 32'h1234_5678);
    chk("r_be", {28'd0, obs_be}, 32'hF);
    chk("r_lat", obs_lat, 32'd3);

    apb_xfer(1'b0, 32'h0000_0014, 32'h0, 4'h0, 3, 32'hCAFE_F00D, 3'd0, 1'b0);
    chk("rw_csb", obs_csb_low, 32'd4);
    chk("rw_acc", obs_acc, 32'd1);
    chk("rw_lat", obs_lat, 32'd6);
    chk("rw_prdata", obs_prdata, 32'hCAFE_F00D);

    apb_xfer(1'b0, 32'h0000_0020, 32'h0, 4'h0, 50, 32'h0, 3'd0, 1'b0);
    chk("to_csb", obs_csb_low, 32'd8);
    chk("to_pulse", {31'd0, obs_tmo}, 32'd1);
    chk("to_prdata", obs_prdata, 32'hDEAD_DEAD);
    chk("to_slverr", {31'd0, obs_pslverr}, 32'd1);
    chk("to_err", {28'd0, err_cnt_o}, 32'd1);

    apb_xfer(1'b1, 32'h0000_0030, 32'h1111_2222, 4'hC, 1, 32'h0, 3'd2, 1'b0);
    chk("we_slverr", {31'd0, obs_pslverr}, 32'd1);
    chk("we_prdata", obs_prdata, 32'd0);
    chk("we_err", {28'd0, err_cnt_o}, 32'd2);

    // Reset while the request is outstanding.
    m_t0 = cyc; m_delay = 20; m_wr = 1'b1; m_addr = 32'h0000_0088; m_wdata = 32'h5555_AAAA;
    m_strb = 4'h9; m_rdata = '0; m_resp = '0; m_tmo = 1'b1;
    psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b1;
    paddr_i = m_addr; pwdata_i = m_wdata; pstrb_i = m_strb;
    drive_slave();
    @(posedge clk_i); #2; penable_i = 1'b1; drive_slave();
    @(posedge clk_i); #2; drive_slave();
    resetn_i = 1'b0; m_t0 = -100; m_err = 0;
    #1;
    chk("mrst_csb", {31'd0, bus_csb_o}, 32'd1);
    chk("mrst_pready", {31'd0, pready_o}, 32'd0);
    chk("mrst_be", {28'd0, bus_byte_en_o}, 32'd0);
    chk("mrst_addr", {8'd0, bus_address_o}, 32'd0);
    chk("mrst_err", {28'd0, err_cnt_o}, 32'd0);
    psel_i = 1'b0; penable_i = 1'b0;
    @(posedge clk_i); #2;
    resetn_i = 1'b1;
    @(posedge clk_i); #2;
    apb_xfer(1'b0, 32'h0000_0090, 32'h0, 4'h0, 0, 32'h0BAD_BEEF, 3'd0, 1'b0);
    chk("post_rst_prdata", obs_prdata, 32'h0BAD_BEEF);

    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 9);
      d = (r < 7) ? (r % 4) : $urandom_range(4, 10);
      apb_xfer(1'($urandom), $urandom, $urandom, 4'($urandom), d, $urandom,
               ($urandom_range(0, 5) == 0) ? 3'($urandom_range(1, 7)) : 3'd0,
               $urandom_range(0, 7) == 0);
      gaps = $urandom_range(0, 2);
      for (int g = 0; g < gaps; g++) begin
        psel_i = 1'($urandom); penable_i = 1'b1;
        bus_ready_i = 1'($urandom); bus_read_data_i = $urandom; bus_response_i = 3'($urandom);
        @(posedge clk_i); #2;
      end
      psel_i = 1'b0; penable_i = 1'b0;
    end

    do_reset();
    @(posedge clk_i); #2;
    for (int i = 0; i < 17; i++) begin
      apb_xfer(1'b1, 32'h100 + i * 4, $urandom, 4'hF, 0, 32'h0, 3'd2, 1'b0);
    end
    chk("sat_err", {28'd0, err_cnt_o}, 32'hF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
